// File: rtl/param_mac_pipe_if.sv
`default_nettype none
// ============================================================================
// Module   : param_mac_pipe_if
// Purpose  : Beat-in / result-out handshake bundle for param_mac_pipe.
// Revision : 1.0  initial release
// ============================================================================
interface param_mac_pipe_if #(
    parameter int WIDTH     = 8,
    parameter int ACC_WIDTH = 20,
    parameter int CNT_WIDTH = 4
);
    logic                        in_valid;
    logic                        in_ready;
    logic signed [WIDTH-1:0]     a;
    logic signed [WIDTH-1:0]     b;
    logic                        first;
    logic                        last;
    logic                        out_valid;
    logic                        out_ready;
    logic signed [ACC_WIDTH-1:0] acc;
    logic [CNT_WIDTH-1:0]        count;
    logic                        ovf;

    modport master (
        output in_valid, a, b, first, last, out_ready,
        input  in_ready, out_valid, acc, count, ovf
    );

    modport slave (
        input  in_valid, a, b, first, last, out_ready,
        output in_ready, out_valid, acc, count, ovf
    );
endinterface
`default_nettype wire

// File: rtl/param_mac_pipe.sv
`default_nettype none
// ============================================================================
// Module   : param_mac_pipe
// Purpose  : 3-stage signed multiply-accumulate over framed vectors with
//            valid/ready backpressure. Optional saturation: MAC_SAT_EN.
// Revision : 1.0  initial release
// ============================================================================
module param_mac_pipe #(
    parameter int WIDTH     = 8,
    parameter int ACC_WIDTH = 20,
    parameter int CNT_WIDTH = 4
) (
    input  wire logic         clk,
    input  wire logic         reset,
    param_mac_pipe_if.slave   mac
);

    localparam int                       c_PROD_W  = 2 * WIDTH;
    localparam logic [CNT_WIDTH-1:0]     c_CNT_MAX = {CNT_WIDTH{1'b1}};
    localparam logic [CNT_WIDTH-1:0]     c_CNT_ONE = CNT_WIDTH'(1);

    logic                        w_stall;

    logic                        r_s1_valid;
    logic                        r_s1_first;
    logic                        r_s1_last;
    logic signed [WIDTH-1:0]     r_s1_a;
    logic signed [WIDTH-1:0]     r_s1_b;

    logic                        r_s2_valid;
    logic                        r_s2_first;
    logic                        r_s2_last;
    logic signed [c_PROD_W-1:0]  r_s2_prod;

    logic signed [ACC_WIDTH-1:0] r_acc;
    logic [CNT_WIDTH-1:0]        r_cnt;
    logic                        r_open;

    logic                        r_out_valid;
    logic signed [ACC_WIDTH-1:0] r_out_acc;
    logic [CNT_WIDTH-1:0]        r_out_count;
    logic                        r_out_ovf;

    logic                        w_start;
    logic signed [ACC_WIDTH-1:0] w_prod_ext;
    logic signed [ACC_WIDTH-1:0] w_base;
    logic signed [ACC_WIDTH-1:0] w_sum;
    logic signed [ACC_WIDTH-1:0] w_acc_next;
    logic [CNT_WIDTH-1:0]        w_cnt_next;
    logic                        w_ovf_next;
    logic                        w_s3_fire;

    // A pending result the consumer has not taken freezes every stage.
    assign w_stall      = r_out_valid & ~mac.out_ready;
    assign w_s3_fire    = r_s2_valid & ~w_stall;

    assign mac.in_ready  = ~w_stall;
    assign mac.out_valid = r_out_valid;
    assign mac.acc       = r_out_acc;
    assign mac.count     = r_out_count;
    assign mac.ovf       = r_out_ovf;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1_valid <= 1'b0;
            r_s1_first <= 1'b0;
            r_s1_last  <= 1'b0;
            r_s1_a     <= '0;
            r_s1_b     <= '0;
        end else if (!w_stall) begin
            r_s1_valid <= mac.in_valid;
            r_s1_first <= mac.first;
            r_s1_last  <= mac.last;
            r_s1_a     <= mac.a;
            r_s1_b     <= mac.b;
        end
    end

    // Operands widened before the multiply so (-2^(W-1))^2 stays exact.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_s2_valid <= 1'b0;
            r_s2_first <= 1'b0;
            r_s2_last  <= 1'b0;
            r_s2_prod  <= '0;
        end else if (!w_stall) begin
            r_s2_valid <= r_s1_valid;
            r_s2_first <= r_s1_first;
            r_s2_last  <= r_s1_last;
            r_s2_prod  <= c_PROD_W'(r_s1_a) * c_PROD_W'(r_s1_b);
        end
    end

    always_comb begin
        w_start    = r_s2_first | ~r_open;
        w_prod_ext = ACC_WIDTH'(r_s2_prod);
        w_base     = w_start ? '0 : r_acc;
        w_sum      = w_base + w_prod_ext;
        if (w_start) begin
            w_cnt_next = c_CNT_ONE;
        end else if (r_cnt == c_CNT_MAX) begin
            w_cnt_next = r_cnt;
        end else begin
            w_cnt_next = r_cnt + c_CNT_ONE;
        end
    end

`ifdef MAC_SAT_EN
    localparam logic signed [ACC_WIDTH-1:0] c_ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] c_ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

    logic r_sat_pos;
    logic r_sat_neg;
    logic r_ovf;
    logic w_pos_held;
    logic w_neg_held;
    logic w_ovf_add;
    logic w_sat_pos_next;
    logic w_sat_neg_next;

    // Once clamped, the vector stays pinned to that rail until the next start.
    always_comb begin
        w_pos_held     = ~w_start & r_sat_pos;
        w_neg_held     = ~w_start & r_sat_neg;
        w_ovf_add      = (w_base[ACC_WIDTH-1] == w_prod_ext[ACC_WIDTH-1]) &&
                         (w_sum[ACC_WIDTH-1] != w_base[ACC_WIDTH-1]);
        w_sat_pos_next = w_pos_held | (~w_neg_held & w_ovf_add & ~w_base[ACC_WIDTH-1]);
        w_sat_neg_next = w_neg_held | (~w_pos_held & w_ovf_add &  w_base[ACC_WIDTH-1]);
        w_ovf_next     = (~w_start & r_ovf) | w_ovf_add;
        if (w_sat_pos_next) begin
            w_acc_next = c_ACC_MAX;
        end else if (w_sat_neg_next) begin
            w_acc_next = c_ACC_MIN;
        end else begin
            w_acc_next = w_sum;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sat_pos <= 1'b0;
            r_sat_neg <= 1'b0;
            r_ovf     <= 1'b0;
        end else if (w_s3_fire) begin
            r_sat_pos <= w_sat_pos_next;
            r_sat_neg <= w_sat_neg_next;
            r_ovf     <= w_ovf_next;
        end
    end
`else
    always_comb begin
        w_acc_next = w_sum;
        w_ovf_next = 1'b0;
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_acc  <= '0;
            r_cnt  <= '0;
            r_open <= 1'b0;
        end else if (w_s3_fire) begin
            r_acc  <= w_acc_next;
            r_cnt  <= w_cnt_next;
            r_open <= ~r_s2_last;
        end
    end

    // out_valid follows S3 every unstalled cycle, so it drops after a
    // handshake unless another last beat lands in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_valid <= 1'b0;
            r_out_acc   <= '0;
            r_out_count <= '0;
            r_out_ovf   <= 1'b0;
        end else if (!w_stall) begin
            r_out_valid <= r_s2_valid & r_s2_last;
            if (r_s2_valid && r_s2_last) begin
                r_out_acc   <= w_acc_next;
                r_out_count <= w_cnt_next;
                r_out_ovf   <= w_ovf_next;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_param_mac_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_param_mac_pipe
// Purpose  : Directed self-checking bench for param_mac_pipe (ACC 20 and 16).
// Revision : 1.0  initial release
// ============================================================================
module tb_param_mac_pipe;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    param_mac_pipe_if #(.WIDTH(8), .ACC_WIDTH(20), .CNT_WIDTH(4)) if0 ();
    param_mac_pipe_if #(.WIDTH(8), .ACC_WIDTH(16), .CNT_WIDTH(4)) if1 ();

    param_mac_pipe #(.WIDTH(8), .ACC_WIDTH(20), .CNT_WIDTH(4)) u_dut0 (
        .clk   (clk),
        .reset (reset),
        .mac   (if0.slave)
    );

    param_mac_pipe #(.WIDTH(8), .ACC_WIDTH(16), .CNT_WIDTH(4)) u_dut1 (
        .clk   (clk),
        .reset (reset),
        .mac   (if1.slave)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    int q0_acc[$];
    int q0_cnt[$];
    int q0_cyc[$];
    int q1_acc[$];
    int q1_ovf[$];

    always @(posedge clk) cyc <= cyc + 1;

    // Handshakes are recorded half a cycle ahead of the edge that completes them.
    always @(negedge clk) begin
        if (reset === 1'b0 && if0.out_valid === 1'b1 && if0.out_ready === 1'b1) begin
            q0_acc.push_back(int'(if0.acc));
            q0_cnt.push_back(int'(if0.count));
            q0_cyc.push_back(cyc);
        end
        if (reset === 1'b0 && if1.out_valid === 1'b1 && if1.out_ready === 1'b1) begin
            q1_acc.push_back(int'(if1.acc));
            q1_ovf.push_back(int'(if1.ovf));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        if0.in_valid = 1'b0; if0.first = 1'b0; if0.last = 1'b0;
        if1.in_valid = 1'b0; if1.first = 1'b0; if1.last = 1'b0;
    endtask

    task automatic drive0(input int av, input int bv, input bit f, input bit l);
        if0.in_valid = 1'b1;
        if0.a        = av[7:0];
        if0.b        = bv[7:0];
        if0.first    = f;
        if0.last     = l;
        tick();
    endtask

    task automatic drive1(input int av, input int bv, input bit f, input bit l);
        if1.in_valid = 1'b1;
        if1.a        = av[7:0];
        if1.b        = bv[7:0];
        if1.first    = f;
        if1.last     = l;
        tick();
    endtask

    task automatic clear_queues();
        q0_acc.delete(); q0_cnt.delete(); q0_cyc.delete();
        q1_acc.delete(); q1_ovf.delete();
    endtask

    task automatic test_reset();
        idle();
        if0.a = '0; if0.b = '0; if0.out_ready = 1'b1;
        if1.a = '0; if1.b = '0; if1.out_ready = 1'b1;
        reset = 1'b1;
        tick();
        tick();
        checks++; if (if0.in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", if0.in_ready); end
        checks++; if (if0.out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", if0.out_valid); end
        checks++; if (int'(if0.acc) !== 0) begin failures++; $display("FAIL reset_acc got=%0d exp=0", int'(if0.acc)); end
        checks++; if (if0.count !== 4'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", if0.count); end
        checks++; if (if0.ovf !== 1'b0) begin failures++; $display("FAIL reset_ovf got=%b exp=0", if0.ovf); end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_single_beat();
        clear_queues();
        drive0(-128, -128, 1'b1, 1'b1);
        idle();
        checks++; if (if0.out_valid !== 1'b0) begin failures++; $display("FAIL single_lat_t1 got=%b exp=0", if0.out_valid); end
        tick();
        checks++; if (if0.out_valid !== 1'b0) begin failures++; $display("FAIL single_lat_t2 got=%b exp=0", if0.out_valid); end
        tick();
        checks++; if (if0.out_valid !== 1'b1) begin failures++; $display("FAIL single_lat_t3 got=%b exp=1", if0.out_valid); end
        checks++; if (int'(if0.acc) !== 16384) begin failures++; $display("FAIL single_acc got=%0d exp=16384", int'(if0.acc)); end
        checks++; if (if0.count !== 4'd1) begin failures++; $display("FAIL single_count got=%0d exp=1", if0.count); end
        tick();
        checks++; if (if0.out_valid !== 1'b0) begin failures++; $display("FAIL single_drop got=%b exp=0", if0.out_valid); end
        repeat (3) tick();
        checks++; if (q0_acc.size() !== 1) begin failures++; $display("FAIL single_results got=%0d exp=1", q0_acc.size()); end
    endtask

    task automatic test_vector8();
        clear_queues();
        for (int i = 0; i < 8; i++) begin
            checks++; if (if0.in_ready !== 1'b1) begin failures++; $display("FAIL vec8_in_ready beat=%0d got=%b exp=1", i, if0.in_ready); end
            drive0(100, -50, (i == 0), (i == 7));
        end
        idle();
        repeat (6) tick();
        checks++; if (q0_acc.size() !== 1) begin failures++; $display("FAIL vec8_results got=%0d exp=1", q0_acc.size()); end
        if (q0_acc.size() >= 1) begin
            checks++; if (q0_acc[0] !== -40000) begin failures++; $display("FAIL vec8_acc got=%0d exp=-40000", q0_acc[0]); end
            checks++; if (q0_cnt[0] !== 8) begin failures++; $display("FAIL vec8_count got=%0d exp=8", q0_cnt[0]); end
        end
    endtask

    task automatic test_overflow();
        int exp_acc;
        int exp_ovf;
`ifdef MAC_SAT_EN
        exp_acc = 32767;
        exp_ovf = 1;
`else
        exp_acc = -17149;
        exp_ovf = 0;
`endif
        clear_queues();
        drive1(127, 127, 1'b1, 1'b0);
        drive1(127, 127, 1'b0, 1'b0);
        drive1(127, 127, 1'b0, 1'b1);
        drive1(1, 1, 1'b1, 1'b1);
        idle();
        repeat (6) tick();
        checks++; if (q1_acc.size() !== 2) begin failures++; $display("FAIL ovf_results got=%0d exp=2", q1_acc.size()); end
        if (q1_acc.size() >= 2) begin
            checks++; if (q1_acc[0] !== exp_acc) begin failures++; $display("FAIL ovf_acc got=%0d exp=%0d", q1_acc[0], exp_acc); end
            checks++; if (q1_ovf[0] !== exp_ovf) begin failures++; $display("FAIL ovf_flag got=%0d exp=%0d", q1_ovf[0], exp_ovf); end
            checks++; if (q1_acc[1] !== 1) begin failures++; $display("FAIL ovf_next_acc got=%0d exp=1", q1_acc[1]); end
            checks++; if (q1_ovf[1] !== 0) begin failures++; $display("FAIL ovf_next_flag got=%0d exp=0", q1_ovf[1]); end
        end
    endtask

    task automatic test_back_to_back();
        clear_queues();
        if0.out_ready = 1'b0;
        drive0(3, 4, 1'b1, 1'b1);
        drive0(-5, 6, 1'b1, 1'b1);
        idle();
        tick();
        for (int i = 0; i < 5; i++) begin
            checks++; if (if0.out_valid !== 1'b1) begin failures++; $display("FAIL stall_valid cyc=%0d got=%b exp=1", i, if0.out_valid); end
            checks++; if (int'(if0.acc) !== 12) begin failures++; $display("FAIL stall_acc cyc=%0d got=%0d exp=12", i, int'(if0.acc)); end
            checks++; if (if0.in_ready !== 1'b0) begin failures++; $display("FAIL stall_in_ready cyc=%0d got=%b exp=0", i, if0.in_ready); end
            tick();
        end
        if0.out_ready = 1'b1;
        repeat (5) tick();
        checks++; if (q0_acc.size() !== 2) begin failures++; $display("FAIL b2b_results got=%0d exp=2", q0_acc.size()); end
        if (q0_acc.size() >= 2) begin
            checks++; if (q0_acc[0] !== 12) begin failures++; $display("FAIL b2b_first got=%0d exp=12", q0_acc[0]); end
            checks++; if (q0_acc[1] !== -30) begin failures++; $display("FAIL b2b_second got=%0d exp=-30", q0_acc[1]); end
            checks++; if (q0_cyc[1] - q0_cyc[0] !== 1) begin failures++; $display("FAIL b2b_spacing got=%0d exp=1", q0_cyc[1] - q0_cyc[0]); end
        end
    endtask

    task automatic test_discard();
        clear_queues();
        drive0(2, 2, 1'b1, 1'b0);
        drive0(3, 3, 1'b0, 1'b0);
        drive0(1, 7, 1'b1, 1'b1);
        idle();
        repeat (6) tick();
        checks++; if (q0_acc.size() !== 1) begin failures++; $display("FAIL discard_results got=%0d exp=1", q0_acc.size()); end
        if (q0_acc.size() >= 1) begin
            checks++; if (q0_acc[0] !== 7) begin failures++; $display("FAIL discard_acc got=%0d exp=7", q0_acc[0]); end
            checks++; if (q0_cnt[0] !== 1) begin failures++; $display("FAIL discard_count got=%0d exp=1", q0_cnt[0]); end
        end
    endtask

    task automatic test_reset_mid();
        clear_queues();
        drive0(2, 2, 1'b1, 1'b0);
        drive0(3, 3, 1'b0, 1'b0);
        idle();
        reset = 1'b1;
        tick();
        checks++; if (if0.out_valid !== 1'b0) begin failures++; $display("FAIL rstmid_valid got=%b exp=0", if0.out_valid); end
        checks++; if (int'(if0.acc) !== 0) begin failures++; $display("FAIL rstmid_acc got=%0d exp=0", int'(if0.acc)); end
        checks++; if (if0.count !== 4'd0) begin failures++; $display("FAIL rstmid_count got=%0d exp=0", if0.count); end
        checks++; if (if0.in_ready !== 1'b1) begin failures++; $display("FAIL rstmid_in_ready got=%b exp=1", if0.in_ready); end
        reset = 1'b0;
        drive0(5, 5, 1'b1, 1'b1);
        idle();
        repeat (6) tick();
        checks++; if (q0_acc.size() !== 1) begin failures++; $display("FAIL rstmid_results got=%0d exp=1", q0_acc.size()); end
        if (q0_acc.size() >= 1) begin
            checks++; if (q0_acc[0] !== 25) begin failures++; $display("FAIL rstmid_after_acc got=%0d exp=25", q0_acc[0]); end
            checks++; if (q0_cnt[0] !== 1) begin failures++; $display("FAIL rstmid_after_count got=%0d exp=1", q0_cnt[0]); end
        end
    endtask

    initial begin
        test_reset();
        test_single_beat();
        test_vector8();
        test_overflow();
        test_back_to_back();
        test_discard();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
